// File: rtl/nn_accel_pkg.sv
// Shared definitions for the neural-network accelerator datapath blocks:
// default layer geometry and the argmax stage FSM encoding.
package nn_accel_pkg;

   localparam int NN_OUTPUT_SIZE = 10;
   localparam int NN_DATA_WIDTH  = 16;
   localparam int NN_IDX_WIDTH   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } argmax_state_t;

endpackage

// File: rtl/nn_argmax.sv
// Output-layer argmax. Consumes OUTPUT_SIZE signed scores per inference and
// holds the index and value of the largest one until the next start/clear.
// Ties resolve to the lowest index because only a strictly greater score
// replaces the running maximum.
//
// Score stream handshake: a beat transfers on a rising edge where both
// score_valid and score_ready are high. score_ready is a register driven
// only by FSM state (never by score_valid), so upstream may hold
// score_valid/score_data/score_last stable until the transfer happens.
module nn_argmax
   import nn_accel_pkg::*;
#(
   parameter int OUTPUT_SIZE = NN_OUTPUT_SIZE,
   parameter int DATA_WIDTH  = NN_DATA_WIDTH,
   parameter int IDX_WIDTH   = NN_IDX_WIDTH
) (
   input  logic                         S_AXI_ACLK,
   input  logic                         S_AXI_ARESETN,
   input  logic                         clear,
   input  logic                         start,
   input  logic                         score_valid,
   output logic                         score_ready,
   input  logic signed [DATA_WIDTH-1:0] score_data,
   input  logic                         score_last,
   output logic                         busy,
   output logic                         done,
   output logic        [IDX_WIDTH-1:0]  predicted_digit,
   output logic signed [DATA_WIDTH-1:0] max_score,
   output logic                         error,
   output argmax_state_t                state_dbg
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_SIZE - 1);

   argmax_state_t                state;
   logic        [IDX_WIDTH-1:0]  count;
   logic        [IDX_WIDTH-1:0]  index_q;
   logic signed [DATA_WIDTH-1:0] max_q;
   logic                         error_q;
   logic                         ready_q;

   logic handshake;
   logic at_last_idx;
   logic is_better;

   // Handshake decode and running-maximum compare
   always_comb begin
      handshake   = score_valid && ready_q;
      at_last_idx = (count == LAST_IDX);
      is_better   = (score_data > max_q);
   end

   // FSM plus score accumulation; clear shares the reset path so it wins
   // over start and any pending handshake
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN || clear) begin
         state   <= ST_IDLE;
         count   <= '0;
         index_q <= '0;
         max_q   <= '0;
         error_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_ACCUM;
                  count   <= '0;
                  index_q <= '0;
                  max_q   <= '0;
                  error_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (handshake) begin
                  count <= count + 1'b1;
                  // First beat loads unconditionally; later beats only on a
                  // strictly larger score
                  if ((count == '0) || is_better) begin
                     max_q   <= score_data;
                     index_q <= count;
                  end
                  // Frame ends on the expected final beat or on an early
                  // score_last; any disagreement between the two is a
                  // framing error
                  if (at_last_idx || score_last) begin
                     state   <= ST_DONE;
                     ready_q <= 1'b0;
                     if (at_last_idx != score_last) begin
                        error_q <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Status and result outputs
   always_comb begin
      score_ready     = ready_q;
      busy            = (state == ST_ACCUM);
      done            = (state == ST_DONE);
      predicted_digit = index_q;
      max_score       = max_q;
      error           = error_q;
      state_dbg       = state;
   end

endmodule

// File: tb/tb_nn_argmax.sv
// Self-checking bench for nn_argmax: directed vector table, hand-written
// framing/abort sequences, and randomized frames against an argmax model.
module tb_nn_argmax;
   import nn_accel_pkg::*;

   localparam int N  = 10;
   localparam int W  = 16;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 clear;
   logic                 start;
   logic                 score_valid;
   logic                 score_ready;
   logic signed [W-1:0]  score_data;
   logic                 score_last;
   logic                 busy;
   logic                 done;
   logic        [IW-1:0] predicted_digit;
   logic signed [W-1:0]  max_score;
   logic                 error;
   argmax_state_t        state_dbg;

   int total = 0;
   int bad   = 0;

   // expected result per frame: {error, index, max}
   logic [W+IW:0] exp_q[$];

   typedef struct {
      string name;
      int    s[N];
      int    last_pos;
      int    e_idx;
      int    e_max;
      bit    e_err;
   } vec_t;

   vec_t vecs[7];

   nn_argmax #(.OUTPUT_SIZE(N), .DATA_WIDTH(W), .IDX_WIDTH(IW)) dut (
      .S_AXI_ACLK      (clk),
      .S_AXI_ARESETN   (rstn),
      .clear           (clear),
      .start           (start),
      .score_valid     (score_valid),
      .score_ready     (score_ready),
      .score_data      (score_data),
      .score_last      (score_last),
      .busy            (busy),
      .done            (done),
      .predicted_digit (predicted_digit),
      .max_score       (max_score),
      .error           (error),
      .state_dbg       (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_done"},  int'(done), 0);
      check({tag, "_ready"}, int'(score_ready), 0);
      check({tag, "_pred"},  int'(predicted_digit), 0);
      check({tag, "_max"},   int'(max_score), 0);
      check({tag, "_err"},   int'(error), 0);
      check({tag, "_state"}, int'(state_dbg), int'(ST_IDLE));
   endtask

   // reference: argmax over the accepted prefix of a frame, strict > so the
   // earliest maximum wins; last_pos==N means score_last never asserted
   function automatic logic [W+IW:0] model(input int s[N], input int last_pos);
      int n, best, best_i;
      bit err;
      n      = (last_pos < N-1) ? last_pos + 1 : N;
      best   = s[0];
      best_i = 0;
      for (int i = 1; i < n; i++) begin
         if (s[i] > best) begin
            best   = s[i];
            best_i = i;
         end
      end
      err = (last_pos != N-1);
      return {err, IW'(best_i), W'(best)};
   endfunction

   // drivers (called at a negedge, return at a negedge)
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive_beat(input int v, input bit last);
      bit accepted;
      int budget;
      score_valid = 1'b1;
      score_data  = W'(v);
      score_last  = last;
      budget      = 0;
      forever begin
         accepted = score_ready;
         @(negedge clk);
         if (accepted) break;
         budget++;
         if (budget > 20) begin
            check("beat_timeout", 0, 1);
            break;
         end
      end
      score_valid = 1'b0;
      score_last  = 1'b0;
   endtask

   // scoreboard pop and compare against the held result
   task automatic check_result(input string tag);
      logic [W+IW:0] e;
      check({tag, "_done"},  int'(done), 1);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_ready"}, int'(score_ready), 0);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_err"},  int'(error), int'(e[W+IW]));
         check({tag, "_pred"}, int'(predicted_digit), int'(e[W+IW-1:W]));
         check({tag, "_max"},  int'(max_score), int'($signed(e[W-1:0])));
      end
   endtask

   task automatic run_frame(input string tag, input int s[N], input int last_pos,
                            input bit gaps, input logic [W+IW:0] expv);
      int n;
      n = (last_pos < N-1) ? last_pos + 1 : N;
      exp_q.push_back(expv);
      pulse_start();
      check({tag, "_start_busy"},  int'(busy), 1);
      check({tag, "_start_ready"}, int'(score_ready), 1);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
               start = $urandom_range(0, 1) == 1;
               @(negedge clk);
               start = 1'b0;
            end
         end
         drive_beat(s[i], i == last_pos);
      end
      check_result(tag);
   endtask

   initial begin
      int s[N];
      logic [15:0] r;
      int lp;

      rstn = 1'b0; clear = 1'b0; start = 1'b0;
      score_valid = 1'b0; score_data = '0; score_last = 1'b0;

      // directed vector table
      vecs[0].name = "v_basic";   vecs[0].s = '{3, -5, 7, 2, 7, 0, 1, -1, 4, 6};
      vecs[0].last_pos = 9; vecs[0].e_idx = 2; vecs[0].e_max = 7;      vecs[0].e_err = 0;
      vecs[1].name = "v_allmin";
      vecs[1].s = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      vecs[1].last_pos = 9; vecs[1].e_idx = 0; vecs[1].e_max = -32768; vecs[1].e_err = 0;
      vecs[2].name = "v_early";   vecs[2].s = '{1, 9, 2, 3, 4, 0, 0, 0, 0, 0};
      vecs[2].last_pos = 4; vecs[2].e_idx = 1; vecs[2].e_max = 9;      vecs[2].e_err = 1;
      vecs[3].name = "v_desc";    vecs[3].s = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
      vecs[3].last_pos = 9; vecs[3].e_idx = 0; vecs[3].e_max = -1;     vecs[3].e_err = 0;
      vecs[4].name = "v_maxend";  vecs[4].s = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32767};
      vecs[4].last_pos = 9; vecs[4].e_idx = 9; vecs[4].e_max = 32767;  vecs[4].e_err = 0;
      vecs[5].name = "v_last0";   vecs[5].s = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[5].last_pos = 0; vecs[5].e_idx = 0; vecs[5].e_max = 5;      vecs[5].e_err = 1;
      vecs[6].name = "v_tie";     vecs[6].s = '{-3, 4, 4, -100, 4, 1, 2, 3, 4, 0};
      vecs[6].last_pos = 9; vecs[6].e_idx = 1; vecs[6].e_max = 4;      vecs[6].e_err = 0;

      // reset
      @(negedge clk);
      @(negedge clk);
      check_idle("reset");
      rstn = 1'b1;
      @(negedge clk);
      check_idle("idle_hold");

      // beats offered in IDLE are not taken
      score_valid = 1'b1;
      score_data  = 16'sd55;
      @(negedge clk);
      check("idle_no_ready", int'(score_ready), 0);
      score_valid = 1'b0;

      foreach (vecs[k]) begin
         run_frame(vecs[k].name, vecs[k].s, vecs[k].last_pos, 1'b0,
                   {vecs[k].e_err, IW'(vecs[k].e_idx), W'(vecs[k].e_max)});
      end

      // ten beats without score_last, then an eleventh beat that must stall
      exp_q.push_back({1'b1, 4'd6, 16'sd70});
      pulse_start();
      for (int i = 0; i < N; i++) drive_beat((i == 6) ? 70 : i * 3, 1'b0);
      check_result("nolast");
      score_valid = 1'b1;
      score_data  = 16'sd1000;
      score_last  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check("extra_stall_ready", int'(score_ready), 0);
         @(negedge clk);
      end
      check("extra_hold_done", int'(done), 1);
      check("extra_hold_pred", int'(predicted_digit), 6);
      check("extra_hold_max",  int'(max_score), 70);
      score_valid = 1'b0;
      score_last  = 1'b0;

      // clear mid-frame, with start and a valid beat competing
      pulse_start();
      for (int i = 0; i < 5; i++) drive_beat(10 * (i + 1), 1'b0);
      clear = 1'b1; start = 1'b1; score_valid = 1'b1; score_data = 16'sd500;
      @(negedge clk);
      clear = 1'b0; start = 1'b0; score_valid = 1'b0;
      check_idle("clear_abort");
      run_frame("after_clear", vecs[0].s, 9, 1'b0, {1'b0, 4'd2, 16'sd7});

      // reset mid-frame
      pulse_start();
      for (int i = 0; i < 5; i++) drive_beat(100 - i, 1'b0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check_idle("rst_abort");
      run_frame("after_rst", vecs[2].s, 4, 1'b0, {1'b1, 4'd1, 16'sd9});

      // clear beats start while holding a result
      clear = 1'b1; start = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0;
      check_idle("clear_prio");

      // randomized frames with gaps and ignored start pulses
      for (int f = 0; f < 40; f++) begin
         bit narrow;
         narrow = $urandom_range(0, 2) == 0;
         for (int i = 0; i < N; i++) begin
            r = 16'($urandom);
            s[i] = narrow ? int'($urandom_range(0, 3)) - 2 : int'($signed(r));
         end
         lp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : N - 1;
         run_frame("rand", s, lp, 1'b1, model(s, lp));
      end

      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nn_argmax.md
NN_ARGMAX -- requirements
Module: nn_argmax

Interface
REQ-001: Parameter OUTPUT_SIZE, default 10, SHALL set the number of class scores per inference.
REQ-002: Parameter DATA_WIDTH, default 16, SHALL set the signed two's-complement score width.
REQ-003: Parameter IDX_WIDTH, default 4, SHALL set the index width, with 2**IDX_WIDTH >= OUTPUT_SIZE.
REQ-004: S_AXI_ACLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005: S_AXI_ARESETN  in  1  SHALL be the reset, synchronous and active-low.
REQ-006: clear  in  1  SHALL be a synchronous active-high soft reset, driven from CONTROL[1].
REQ-007: start  in  1  SHALL be a one-cycle-sampled request to begin a new inference.
REQ-008: score_valid  in  1  SHALL indicate that score_data and score_last are valid.
REQ-009: score_ready  out  1  SHALL indicate that the block accepts a score this cycle.
REQ-010: score_data  in  DATA_WIDTH  SHALL carry the signed output-layer score.
REQ-011: score_last  in  1  SHALL mark the final score of an inference.
REQ-012: busy  out  1  SHALL be high while scores are being accumulated.
REQ-013: done  out  1  SHALL be a level that is high while a result is held.
REQ-014: predicted_digit  out  IDX_WIDTH  SHALL carry the index of the maximum score.
REQ-015: max_score  out  DATA_WIDTH  SHALL carry the maximum score value.
REQ-016: error  out  1  SHALL flag a score_last framing mismatch in the last inference.

Function
REQ-017: The FSM SHALL have three states, IDLE, ACCUM and DONE; busy SHALL equal (state==ACCUM) and done SHALL equal (state==DONE).
REQ-018: In IDLE or DONE, start=1 SHALL move the FSM to ACCUM next cycle and clear count, index, max_score and error.
REQ-019: start SHALL be ignored while in ACCUM.
REQ-020: score_ready SHALL be 1 only in ACCUM, and SHALL be registered with no combinational path from score_valid.
REQ-021: A handshake (score_valid && score_ready) with count==0 SHALL unconditionally load max_score and set index to 0.
REQ-022: A handshake with count>0 SHALL update max_score and index only if score_data > max_score (strict signed compare), so the lowest index wins a tie.
REQ-023: count SHALL increment by 1 on every handshake and SHALL be IDX_WIDTH bits wide.
REQ-024: A handshake with count==OUTPUT_SIZE-1 SHALL move the FSM to DONE next cycle, giving done one cycle after the final handshake.
REQ-025: A handshake with count==OUTPUT_SIZE-1 and score_last==0 SHALL set error=1.
REQ-026: A handshake with score_last==1 and count<OUTPUT_SIZE-1 SHALL set error=1, move the FSM to DONE, and present the partial argmax.
REQ-027: predicted_digit and max_score SHALL remain stable in DONE until the next start or clear.
REQ-028: No score SHALL be accepted in IDLE or DONE; extra beats SHALL stall upstream (score_ready=0).
REQ-029: clear SHALL take priority over start and handshakes, forcing IDLE with all outputs at reset values on the next cycle.

Reset
REQ-030: On S_AXI_ARESETN=0 at a clock edge, the FSM SHALL enter IDLE, and score_ready, busy, done, error, predicted_digit, max_score and count SHALL all be 0.
REQ-031: Reset or clear during ACCUM SHALL abort the inference with no done pulse and no retained partial result.

Structure
REQ-032: The FSM state enum and the OUTPUT_SIZE/DATA_WIDTH defaults SHALL live in the shared package nn_accel_pkg.
REQ-033: The block SHALL be a single module with no sub-modules, and SHALL be instantiated inside nn_accelerator_core after the output layer.

Verification
REQ-034: Scores {3,-5,7,2,7,0,1,-1,4,6}, last on beat 9 -> done one cycle after the last handshake, predicted_digit=2, max_score=7, error=0.
REQ-035: All ten scores equal to -32768 -> predicted_digit=0, max_score=16'h8000.
REQ-036: score_last on beat 4, scores {1,9,2,3,4} -> error=1, done=1, predicted_digit=1.
REQ-037: Ten scores with no score_last, then an eleventh valid beat -> error=1, and score_ready stays 0 for the 11th beat.
REQ-038: clear (and separately S_AXI_ARESETN=0) after beat 5 -> next cycle busy=0, done=0, predicted_digit=0; a new start then gives a correct result.
REQ-039: Random score_valid gaps plus start pulses during ACCUM -> result matches the reference argmax and start has no effect.
